// File: rtl/spart_rx.sv
// SPART serial receiver: 2-flop RxD synchronizer, oversampled 8N1 framing, byte + RDA to the bus side.
// Optional SPART_RX_FRAME_ERR_EN adds a frame_err output flagging a low stop-bit sample.
`timescale 1ns/1ps
module spart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxEnable,
  input  logic                 RxD,
  input  logic                 rx_clear,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 RDA
`ifdef SPART_RX_FRAME_ERR_EN
  ,
  output logic                 frame_err
`endif
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(OVERSAMPLE - 1);
  localparam logic [CW-1:0] CNT_HALF  = CW'(OVERSAMPLE / 2 - 1);
  localparam logic [BW-1:0] BIDX_LAST = BW'(DATA_BITS - 1);

  // Handshake: rx_clear is a one-cycle strobe that drops RDA (and frame_err) on the next
  // edge; a frame completing on that same edge takes priority and leaves RDA set.

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                 state;
  state_t                 state_nxt;
  logic                   sync_q;
  logic                   rxd_s;
  logic [CW-1:0]          cnt;
  logic [CW-1:0]          cnt_nxt;
  logic [BW-1:0]          bidx;
  logic [BW-1:0]          bidx_nxt;
  logic [DATA_BITS-1:0]   sr;
  logic                   shift_en;
  logic                   done;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (rxEnable) begin
      case (state)
        IDLE:    if (!rxd_s) state_nxt = START;
        START:   if (cnt == CNT_HALF) state_nxt = rxd_s ? IDLE : DATA;
        DATA:    if (cnt == CNT_LAST && bidx == BIDX_LAST) state_nxt = STOP;
        STOP:    if (cnt == CNT_LAST) state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Counter/index updates and the sample/complete strobes; everything waits for a tick.
  always_comb begin
    cnt_nxt  = cnt;
    bidx_nxt = bidx;
    shift_en = 1'b0;
    done     = 1'b0;
    if (rxEnable) begin
      case (state)
        IDLE: cnt_nxt = '0;
        START: begin
          if (cnt == CNT_HALF) begin
            cnt_nxt  = '0;
            bidx_nxt = '0;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            cnt_nxt  = '0;
            bidx_nxt = bidx + BW'(1);
            shift_en = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            done    = 1'b1;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
        default: cnt_nxt = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= 1'b1;
      rxd_s   <= 1'b1;
      cnt     <= '0;
      bidx    <= '0;
      sr      <= '0;
      rx_data <= '0;
      RDA     <= 1'b0;
`ifdef SPART_RX_FRAME_ERR_EN
      frame_err <= 1'b0;
`endif
    end else begin
      sync_q <= RxD;
      rxd_s  <= sync_q;
      cnt    <= cnt_nxt;
      bidx   <= bidx_nxt;
      // LSB arrives first, so shifting right lands it in bit 0 after the last sample.
      if (shift_en) sr <= {rxd_s, sr[DATA_BITS-1:1]};
      if (done) begin
        rx_data <= sr;
        RDA     <= 1'b1;
`ifdef SPART_RX_FRAME_ERR_EN
        frame_err <= ~rxd_s;
`endif
      end else if (rx_clear) begin
        RDA <= 1'b0;
`ifdef SPART_RX_FRAME_ERR_EN
        frame_err <= 1'b0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Bench for spart_rx: directed frames plus randomized traffic, checked every cycle against a
// frame-level model (expected completion edge and byte per frame). Honors SPART_RX_FRAME_ERR_EN.
`timescale 1ns/1ps
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rxEnable = 1'b0;
  logic       RxD = 1'b1;
  logic       rx_clear = 1'b0;
  logic [7:0] rx_data;
  logic       RDA;
`ifdef SPART_RX_FRAME_ERR_EN
  logic       frame_err;
`endif

  spart_rx #(.OVERSAMPLE(16), .DATA_BITS(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .rxEnable (rxEnable),
    .RxD      (RxD),
    .rx_clear (rx_clear),
    .rx_data  (rx_data),
    .RDA      (RDA)
`ifdef SPART_RX_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  // ---------------- clock / reset / tick ----------------
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  initial forever #5 clk = ~clk;

  // Oversample tick lands on every posedge whose index is a multiple of 4.
  always @(negedge clk) rxEnable = ((cyc + 1) % 4 == 0);

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int         ev_edge_q[$];
  logic [7:0] exp_q[$];
  logic       ev_stop_q[$];
  logic       exp_rda = 1'b0;
  logic [7:0] exp_data = 8'h00;
  logic       exp_fe = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Line drops just after edge n; the synchronizer makes it visible to the FSM from edge n+3,
  // so detection is the first tick at or after n+3. Then half a start bit, 8 data bits and one
  // stop bit at 16 ticks/bit = 152 ticks = 608 clk to the stop-sample edge.
  function automatic int done_edge(input int n);
    int d;
    d = n + 3;
    while (d % 4 != 0) d++;
    return d + 608;
  endfunction

  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      exp_rda  = 1'b0;
      exp_data = 8'h00;
      exp_fe   = 1'b0;
      ev_edge_q.delete();
      exp_q.delete();
      ev_stop_q.delete();
    end else if (ev_edge_q.size() > 0 && ev_edge_q[0] == cyc) begin
      void'(ev_edge_q.pop_front());
      exp_rda  = 1'b1;
      exp_data = exp_q.pop_front();
      exp_fe   = ~ev_stop_q.pop_front();
    end else if (rx_clear) begin
      exp_rda = 1'b0;
      exp_fe  = 1'b0;
    end
    #1;
    check("cyc_rda", 32'(RDA), 32'(exp_rda));
    check("cyc_rx_data", 32'(rx_data), 32'(exp_data));
`ifdef SPART_RX_FRAME_ERR_EN
    check("cyc_frame_err", 32'(frame_err), 32'(exp_fe));
`endif
  end

  // ---------------- driver tasks (called on a negedge) ----------------
  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    ev_edge_q.push_back(done_edge(cyc));
    exp_q.push_back(b);
    ev_stop_q.push_back(stop);
    for (int i = 0; i < 10; i++) begin
      RxD = bits[i];
      repeat (64) @(negedge clk);
    end
    RxD = 1'b1;
  endtask

  task automatic pulse_clear();
    rx_clear = 1'b1;
    @(negedge clk);
    rx_clear = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int         n_start;
    int         lat;
    int         n;
    int         c_edge;
    int         gap;
    logic [7:0] b;
    logic       stop;
    logic       prev_bad;

    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    check("reset_rda", 32'(RDA), 32'h0);
    check("reset_rx_data", 32'(rx_data), 32'h00);
    repeat (10) @(negedge clk);

    // single byte with latency measurement
    n_start = cyc;
    lat = 0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        n = 0;
        while (RDA !== 1'b1 && n < 700) begin
          @(negedge clk);
          n++;
        end
        lat = cyc - n_start;
      end
    join
    checks++;
    if (lat < 610 || lat > 650) begin
      errors++;
      $display("FAIL a5_latency: got %0d clk, expected 610..650", lat);
    end
    check("a5_rda", 32'(RDA), 32'h1);
    check("a5_rx_data", 32'(rx_data), 32'hA5);
    pulse_clear();
    check("a5_clear_rda", 32'(RDA), 32'h0);
    check("a5_clear_rx_data", 32'(rx_data), 32'hA5);

    // glitch rejection, then a real frame
    RxD = 1'b0;
    repeat (12) @(negedge clk);
    RxD = 1'b1;
    repeat (100) @(negedge clk);
    check("glitch_rda", 32'(RDA), 32'h0);
    send_frame(8'h3C, 1'b1);
    check("post_glitch_rx_data", 32'(rx_data), 32'h3C);
    check("post_glitch_rda", 32'(RDA), 32'h1);

    // back-to-back overrun
    pulse_clear();
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    check("overrun_rx_data", 32'(rx_data), 32'hC3);
    check("overrun_rda", 32'(RDA), 32'h1);

    // clear on the exact completion edge, RDA already set
    c_edge = done_edge(cyc);
    fork
      send_frame(8'h5A, 1'b1);
      begin
        while (cyc < c_edge - 1) @(negedge clk);
        pulse_clear();
      end
    join
    check("collide_rda", 32'(RDA), 32'h1);
    check("collide_rx_data", 32'(rx_data), 32'h5A);

    // reset during data bit 4 of 0xFF
    pulse_clear();
    RxD = 1'b0;
    repeat (64) @(negedge clk);
    RxD = 1'b1;
    repeat (64 * 4 + 32) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    check("midreset_rda", 32'(RDA), 32'h0);
    check("midreset_rx_data", 32'(rx_data), 32'h00);
    send_frame(8'h81, 1'b1);
    check("after_reset_rx_data", 32'(rx_data), 32'h81);

    // break: line held low for a full frame time
    pulse_clear();
    ev_edge_q.push_back(done_edge(cyc));
    exp_q.push_back(8'h00);
    ev_stop_q.push_back(1'b0);
    RxD = 1'b0;
    repeat (640) @(negedge clk);
    RxD = 1'b1;
    repeat (128) @(negedge clk);
    check("break_rx_data", 32'(rx_data), 32'h00);
    check("break_rda", 32'(RDA), 32'h1);

`ifdef SPART_RX_FRAME_ERR_EN
    send_frame(8'h55, 1'b0);
    repeat (128) @(negedge clk);
    check("ferr_rx_data", 32'(rx_data), 32'h55);
    check("ferr_rda", 32'(RDA), 32'h1);
    check("ferr_flag", 32'(frame_err), 32'h1);
    send_frame(8'h0F, 1'b1);
    check("good_stop_rx_data", 32'(rx_data), 32'h0F);
    check("good_stop_flag", 32'(frame_err), 32'h0);
`endif

    // randomized traffic with random clears, some during frames
    prev_bad = 1'b0;
    for (int k = 0; k < 40; k++) begin
      b = 8'($urandom_range(0, 255));
      stop = 1'b1;
`ifdef SPART_RX_FRAME_ERR_EN
      stop = ($urandom_range(0, 3) != 0);
`endif
      gap = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 150);
      if (prev_bad && gap < 64) gap = 64;
      repeat (gap) @(negedge clk);
      if ($urandom_range(0, 2) == 0) pulse_clear();
      if ($urandom_range(0, 1) == 1) begin
        fork
          send_frame(b, stop);
          begin
            repeat ($urandom_range(1, 638)) @(negedge clk);
            pulse_clear();
          end
        join
      end else begin
        send_frame(b, stop);
      end
      prev_bad = ~stop;
    end

    repeat (700) @(negedge clk);
    check("events_drained", 32'(ev_edge_q.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
